// File: rtl/full_report_pkg.sv
// -----------------------------------------------------------------------------
// full_report_pkg
// Shared definitions for the full-event reporter and the counter bank's
// formal harness.
//   lgns()       : channel-index width for a given channel count
//   RST_VALID    : reset value of the output valid flag
//   RST_INDEX    : reset value of o_chan and the round-robin pointer
// Optional feature macro used by the importing files: FULL_REPORT_STAMP_EN
// -----------------------------------------------------------------------------
package full_report_pkg;

   localparam logic RST_VALID = 1'b0;
   localparam int   RST_INDEX = 0;

   // Smallest width able to index n channels (n in 2..32).
   function automatic int lgns(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 6; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/full_event_reporter_if.sv
// -----------------------------------------------------------------------------
// full_event_reporter_if
// Valid/ready event stream carrying the channel index of each full event.
//   o_valid  : event available (reporter -> consumer)
//   i_ready  : consumer accepts when o_valid && i_ready (consumer -> reporter)
//   o_chan   : channel index of the reported event
//   o_stamp  : capture time of the event (only with FULL_REPORT_STAMP_EN)
// Modports: master = reporter side, slave = consumer side.
// -----------------------------------------------------------------------------
interface full_event_reporter_if #(
   parameter int NS = 4
`ifdef FULL_REPORT_STAMP_EN
   , parameter int LGSTAMP = 16
`endif
);
   import full_report_pkg::*;

   localparam int LGNS = lgns(NS);

   logic            o_valid;
   logic            i_ready;
   logic [LGNS-1:0] o_chan;
`ifdef FULL_REPORT_STAMP_EN
   logic [LGSTAMP-1:0] o_stamp;
`endif

`ifdef FULL_REPORT_STAMP_EN
   modport master (output o_valid, output o_chan, output o_stamp, input i_ready);
   modport slave  (input o_valid, input o_chan, input o_stamp, output i_ready);
`else
   modport master (output o_valid, output o_chan, input i_ready);
   modport slave  (input o_valid, input o_chan, output i_ready);
`endif

endinterface

// File: rtl/full_event_reporter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker: finds the first set bit of pending at or
// after rr_ptr, wrapping modulo NS.
//   pending : per-channel pending flags
//   rr_ptr  : channel with highest priority this cycle
//   any     : at least one pending bit is set
//   picked  : index of the selected channel (0 when any == 0)
// -----------------------------------------------------------------------------
module rr_pick
   import full_report_pkg::*;
#(
   parameter int NS   = 4,
   parameter int LGNS = lgns(NS)
) (
   input  logic [NS-1:0]   pending,
   input  logic [LGNS-1:0] rr_ptr,
   output logic            any,
   output logic [LGNS-1:0] picked
);

   int idx;

   // Walk from the farthest offset back to rr_ptr so the nearest hit is the
   // last one written and therefore wins.
   always_comb begin
      // NOTE: every output gets a default before the loop so no path leaves
      // it unassigned, which would otherwise infer a latch.
      any    = 1'b0;
      picked = '0;
      idx    = 0;
      for (int i = NS - 1; i >= 0; i--) begin
         idx = int'(rr_ptr) + i;
         if (idx >= NS) idx = idx - NS;
         if (pending[idx]) begin
            any    = 1'b1;
            picked = LGNS'(idx);
         end
      end
   end

endmodule

// File: rtl/full_event_reporter.sv
// -----------------------------------------------------------------------------
// full_event_reporter
// Watches the per-channel full flags of the saturating-counter bank, turns each
// rising edge into one pending event per channel, and reports pending channels
// round-robin over a registered valid/ready stream. A channel that fills again
// before its previous event was taken sets a sticky overrun flag.
//   i_clk          : clock, rising edge
//   i_reset        : asynchronous, active-high reset
//   i_full         : per-channel full flags (synchronous to i_clk)
//   o_overrun      : sticky per-channel overrun flags
//   i_clr_overrun  : write-1-to-clear for o_overrun (a same-cycle set wins)
//   evt            : event stream (o_valid / i_ready / o_chan [/ o_stamp])
// Optional feature: define FULL_REPORT_STAMP_EN to add a free-running
// LGSTAMP-bit timestamp captured per channel on each rise and reported as
// o_stamp alongside o_chan.
// -----------------------------------------------------------------------------
module full_event_reporter
   import full_report_pkg::*;
#(
   parameter int NS = 4
`ifdef FULL_REPORT_STAMP_EN
   , parameter int LGSTAMP = 16
`endif
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic [NS-1:0]         i_full,
   output logic [NS-1:0]         o_overrun,
   input  logic [NS-1:0]         i_clr_overrun,
   full_event_reporter_if.master evt
);

   localparam int LGNS = lgns(NS);

   logic [NS-1:0]   prev_full;
   logic [NS-1:0]   pending;
   logic [LGNS-1:0] rr_ptr;

   logic [NS-1:0]   rise;
   logic            load;
   logic            any;
   logic [LGNS-1:0] picked;
   logic [NS-1:0]   load_mask;
   logic [LGNS-1:0] next_ptr;

   assign rise = i_full & ~prev_full;

   // The output register refills whenever it is empty or being drained.
   assign load = !evt.o_valid || evt.i_ready;

   // Channel leaving pending this cycle; a rise on that same channel re-arms
   // pending and does not count as an overrun.
   assign load_mask = (load && any) ? (NS'(1) << picked) : '0;

   assign next_ptr = (int'(picked) == NS - 1) ? '0 : picked + 1'b1;

   rr_pick #(
      .NS   (NS),
      .LGNS (LGNS)
   ) u_rr_pick (
      .pending (pending),
      .rr_ptr  (rr_ptr),
      .any     (any),
      .picked  (picked)
   );

`ifdef FULL_REPORT_STAMP_EN
   logic [LGSTAMP-1:0] stamp_ctr;
   logic [LGSTAMP-1:0] stamp_mem [NS];

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) stamp_ctr <= '0;
      else         stamp_ctr <= stamp_ctr + 1'b1;
   end

   // NOTE: the stamp storage has no reset; an entry is only ever read after a
   // rise has written it, so resetting it would add logic without effect.
   always_ff @(posedge i_clk) begin
      for (int n = 0; n < NS; n++) begin
         if (rise[n]) stamp_mem[n] <= stamp_ctr;
      end
   end
`endif

   // NOTE: non-blocking assignments throughout, so every register samples the
   // values from before the edge regardless of statement order.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         prev_full   <= '0;
         pending     <= '0;
         rr_ptr      <= LGNS'(RST_INDEX);
         o_overrun   <= '0;
         evt.o_valid <= RST_VALID;
         evt.o_chan  <= LGNS'(RST_INDEX);
`ifdef FULL_REPORT_STAMP_EN
         evt.o_stamp <= '0;
`endif
      end else begin
         prev_full <= i_full;
         pending   <= (pending & ~load_mask) | rise;
         o_overrun <= (o_overrun & ~i_clr_overrun) | (rise & pending & ~load_mask);
         if (load) begin
            evt.o_valid <= any;
            if (any) begin
               evt.o_chan <= picked;
               rr_ptr     <= next_ptr;
`ifdef FULL_REPORT_STAMP_EN
               evt.o_stamp <= stamp_mem[picked];
`endif
            end
         end
      end
   end

endmodule

// File: tb/tb_full_event_reporter.sv
// -----------------------------------------------------------------------------
// tb_full_event_reporter
// Directed self-checking bench for full_event_reporter with NS = 4. Inputs are
// driven 1 time unit after each rising edge and outputs are sampled at the
// same point. With FULL_REPORT_STAMP_EN the DUT is built with LGSTAMP = 4 and
// the timestamp path is exercised as well.
// -----------------------------------------------------------------------------
module tb_full_event_reporter;

   logic       i_clk;
   logic       i_reset;
   logic [3:0] i_full;
   logic [3:0] o_overrun;
   logic [3:0] i_clr_overrun;

   int n_checks = 0;
   int n_fail   = 0;

`ifdef FULL_REPORT_STAMP_EN
   full_event_reporter_if #(.NS(4), .LGSTAMP(4)) evt ();
   full_event_reporter #(.NS(4), .LGSTAMP(4)) dut (
`else
   full_event_reporter_if #(.NS(4)) evt ();
   full_event_reporter #(.NS(4)) dut (
`endif
      .i_clk         (i_clk),
      .i_reset       (i_reset),
      .i_full        (i_full),
      .o_overrun     (o_overrun),
      .i_clr_overrun (i_clr_overrun),
      .evt           (evt)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout required end of test");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic do_reset(input logic [3:0] full_val);
      i_reset = 1'b1;
      i_full  = full_val;
      tick();
      tick();
      i_reset = 1'b0;
   endtask

   initial begin
      i_reset       = 1'b1;
      i_full        = 4'b0010;
      i_clr_overrun = 4'b0000;
      evt.i_ready   = 1'b0;
      #1;
      check("rst_valid",   32'(evt.o_valid), 32'd0);
      check("rst_chan",    32'(evt.o_chan),  32'd0);
      check("rst_overrun", 32'(o_overrun),   32'd0);
`ifdef FULL_REPORT_STAMP_EN
      check("rst_stamp",   32'(evt.o_stamp), 32'd0);
`endif

      // Full flag already high at reset release is a new event.
      do_reset(4'b0010);
      tick();
      check("rel_valid_c1", 32'(evt.o_valid), 32'd0);
      tick();
      check("rel_valid_c2", 32'(evt.o_valid), 32'd1);
      check("rel_chan_c2",  32'(evt.o_chan),  32'd1);
      check("rel_overrun",  32'(o_overrun),   32'd0);
      evt.i_ready = 1'b1;
      tick();
      check("rel_drained",  32'(evt.o_valid), 32'd0);

      // All four channels rise together, ready held high.
      do_reset(4'b0000);
      evt.i_ready = 1'b1;
      i_full = 4'b1111;
      tick();
      check("all_lat1", 32'(evt.o_valid), 32'd0);
      for (int c = 0; c < 4; c++) begin
         tick();
         check("all_valid", 32'(evt.o_valid), 32'd1);
         check("all_chan",  32'(evt.o_chan),  32'(c));
      end
      tick();
      check("all_empty",   32'(evt.o_valid), 32'd0);
      check("all_overrun", 32'(o_overrun),   32'd0);

      // Channel 2 held under back-pressure.
      i_full = 4'b0000;
      evt.i_ready = 1'b0;
      tick();
      i_full = 4'b0100;
      tick();
      check("bp_lat1", 32'(evt.o_valid), 32'd0);
      tick();
      check("bp_valid", 32'(evt.o_valid), 32'd1);
      check("bp_chan",  32'(evt.o_chan),  32'd2);
      for (int k = 0; k < 5; k++) begin
         tick();
         check("bp_hold_valid", 32'(evt.o_valid), 32'd1);
         check("bp_hold_chan",  32'(evt.o_chan),  32'd2);
      end
      evt.i_ready = 1'b1;
      tick();
      check("bp_accepted", 32'(evt.o_valid), 32'd0);

      // Overrun on channel 1 while channel 0 blocks the output.
      evt.i_ready = 1'b0;
      i_full = 4'b0101;
      tick();
      tick();
      check("ov_blk_valid", 32'(evt.o_valid), 32'd1);
      check("ov_blk_chan",  32'(evt.o_chan),  32'd0);
      i_full = 4'b0111;
      tick();
      check("ov_first_rise", 32'(o_overrun), 32'd0);
      i_full = 4'b0101;
      tick();
      i_full = 4'b0111;
      tick();
      check("ov_set",       32'(o_overrun),   32'b0010);
      check("ov_hold_chan", 32'(evt.o_chan),  32'd0);
      evt.i_ready = 1'b1;
      tick();
      check("ov_rep_valid", 32'(evt.o_valid), 32'd1);
      check("ov_rep_chan",  32'(evt.o_chan),  32'd1);
      tick();
      check("ov_merged",    32'(evt.o_valid), 32'd0);
      check("ov_sticky",    32'(o_overrun),   32'b0010);
      i_clr_overrun = 4'b0010;
      tick();
      i_clr_overrun = 4'b0000;
      check("ov_cleared",   32'(o_overrun),   32'd0);

      // Overrun set and clear in the same cycle: set wins.
      evt.i_ready = 1'b0;
      i_full = 4'b1111;
      tick();
      tick();
      check("sc_blk_chan", 32'(evt.o_chan), 32'd3);
      i_full = 4'b1101;
      tick();
      i_full = 4'b1111;
      tick();
      i_full = 4'b1101;
      tick();
      i_full = 4'b1111;
      i_clr_overrun = 4'b0010;
      tick();
      i_clr_overrun = 4'b0000;
      check("sc_set_wins", 32'(o_overrun), 32'b0010);

      // Three events pending, then an asynchronous reset mid-cycle.
      i_full = 4'b1010;
      tick();
      i_full = 4'b1111;
      tick();
      check("ar_pre_valid",   32'(evt.o_valid), 32'd1);
      check("ar_pre_overrun", 32'(o_overrun),   32'b0010);
      i_full  = 4'b0001;
      i_reset = 1'b1;
      #1;
      check("ar_valid",   32'(evt.o_valid), 32'd0);
      check("ar_overrun", 32'(o_overrun),   32'd0);
      check("ar_chan",    32'(evt.o_chan),  32'd0);
      tick();
      i_reset = 1'b0;
      evt.i_ready = 1'b1;
      tick();
      check("ar_lat1",       32'(evt.o_valid), 32'd0);
      tick();
      check("ar_rep_valid",  32'(evt.o_valid), 32'd1);
      check("ar_rep_chan",   32'(evt.o_chan),  32'd0);
      tick();
      check("ar_only_high",  32'(evt.o_valid), 32'd0);

`ifdef FULL_REPORT_STAMP_EN
      // Stamp capture around the counter wrap (LGSTAMP = 4).
      do_reset(4'b0000);
      evt.i_ready = 1'b1;
      repeat (14) tick();
      i_full = 4'b0001;
      tick();
      tick();
      check("st_chan0",  32'(evt.o_chan),  32'd0);
      check("st_stamp0", 32'(evt.o_stamp), 32'd14);
      tick();
      i_full = 4'b1001;
      tick();
      tick();
      check("st_chan3",  32'(evt.o_chan),  32'd3);
      check("st_stamp3", 32'(evt.o_stamp), 32'd1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/full_event_reporter.md
# full_event_reporter

Downstream consumer of the per-channel saturating-counter bank: watches the NS `full` flags that bank produces and reports each new full event as a channel index over a valid/ready stream. It detects the rising edge of each flag, holds one pending event per channel, serves pending channels round-robin, and flags sticky overruns when a channel fills again before its previous event was reported.

## Interface
- NS, 4, number of channels (2..32); must match the counter bank's NS
- LGNS, $clog2(NS), width of channel index (derived, not overridden)
- LGSTAMP, 16, timestamp width (used only with FULL_REPORT_STAMP_EN)

- i_clk  input  1  sole clock, rising edge
- i_reset  input  1  asynchronous, active-high reset
- i_full  input  NS  per-channel full flags from the counter bank (synchronous to i_clk)
- o_valid  output  1  event available on o_chan
- i_ready  input  1  consumer accepts event when o_valid && i_ready
- o_chan  output  LGNS  channel index of reported event
- o_overrun  output  NS  sticky per-channel overrun flags
- i_clr_overrun  input  NS  write-1-to-clear for o_overrun
- o_stamp  output  LGSTAMP  capture time of reported event (only with FULL_REPORT_STAMP_EN)

## Operation
- prev_full register samples i_full every cycle; rise = i_full & ~prev_full.
- pending[N]: set when rise[N]; cleared when channel N is loaded into the output register; if rise[N] and load of N occur in the same cycle, pending[N] stays set (new event).
- o_overrun[N] set when rise[N] while pending[N]=1 and N is not being loaded that cycle; the second event is merged (not queued). i_clr_overrun[N] clears it; a simultaneous set wins over clear.
- Output register loads when !o_valid || i_ready. Load picks the first set pending bit at or after rr_ptr (wrapping modulo NS); rr_ptr <= picked+1 mod NS. If nothing pending, o_valid <= 0.
- While o_valid && !i_ready: o_chan (and o_stamp) held stable, o_valid held high.
- Reset values: o_valid=0, o_chan=0, o_overrun=0, pending=0, prev_full=0, rr_ptr=0, o_stamp=0, timestamp counter=0.
- Reset mid-operation discards all pending and in-flight events. Because prev_full resets to 0, any i_full already high after reset release is reported as a new event.

## Timing
- i_full rising in cycle k: pending set at edge ending k; o_valid high from cycle k+2 (if output idle), i.e. 2-cycle latency.
- Back-to-back: with i_ready held high, one event per cycle sustained.
- All outputs are registered; no combinational path from i_ready or i_full to any output.
- All NS channels rising in one cycle: reported in order rr_ptr, rr_ptr+1, … over NS consecutive accepted cycles.

## Configuration
- FULL_REPORT_STAMP_EN defined: free-running LGSTAMP-bit counter (wraps at 2^LGSTAMP-1 -> 0); on rise[N] the counter value is captured into stamp[N] (a merged/overrun event overwrites it); o_stamp loads stamp[picked] with o_chan.
- Undefined: no counter, no stamp storage, o_stamp port absent; all other behaviour identical.

## Structure
- Package full_report_pkg: LGNS helper function and the reset constants; shared with the counter bank's formal harness.
- One sub-module: rr_pick — combinational round-robin picker (inputs pending, rr_ptr; outputs any, picked index). Everything sequential stays in full_event_reporter.

## Test plan
- Reset release with i_full=4'b0010 already high -> o_valid=1 at cycle 2 with o_chan=1; no overrun.
- i_full 0->4'b1111 in one cycle, i_ready=1 -> o_chan 0,1,2,3 on four consecutive cycles, then o_valid=0.
- Channel 2 rises, i_ready=0 held 5 cycles -> o_valid=1, o_chan=2 stable throughout; accepted on first i_ready.
- Channel 1 rises, falls, rises again while still pending (i_ready=0) -> o_overrun=4'b0010; one event reported; i_clr_overrun=4'b0010 clears it; simultaneous new overrun + clear leaves it set.
- Assert i_reset for one cycle with 3 events pending -> o_valid=0, o_overrun=0 immediately (asynchronously); only still-high i_full lines re-report.
- With FULL_REPORT_STAMP_EN, LGSTAMP=4: channel 0 rises when counter=14, channel 3 rises at counter=1 (post-wrap) -> o_stamp 14 with o_chan=0, then 1 with o_chan=3.
